// File: rtl/alu_pkg.sv
// Shared op-codes, MDU state encoding and op classification for the alu_mdu datapath.
package alu_pkg;

   localparam logic [4:0] OP_AND   = 5'b00000;
   localparam logic [4:0] OP_OR    = 5'b00001;
   localparam logic [4:0] OP_ADD   = 5'b00010;
   localparam logic [4:0] OP_XOR   = 5'b00011;
   localparam logic [4:0] OP_SUB   = 5'b00110;
   localparam logic [4:0] OP_SLT   = 5'b00111;
   localparam logic [4:0] OP_SLTU  = 5'b01000;
   localparam logic [4:0] OP_SLL   = 5'b01001;
   localparam logic [4:0] OP_SRL   = 5'b01010;
   localparam logic [4:0] OP_SRA   = 5'b01011;
   localparam logic [4:0] OP_NOR   = 5'b01100;
   localparam logic [4:0] OP_MULT  = 5'b10000;
   localparam logic [4:0] OP_MULTU = 5'b10001;
   localparam logic [4:0] OP_DIV   = 5'b10010;
   localparam logic [4:0] OP_DIVU  = 5'b10011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   // Only 100xx codes launch the multiply/divide unit.
   function automatic logic is_mdu_op(input logic [4:0] code);
      return code[4] && (code[3:2] == 2'b00);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per cycle on
// operand magnitudes, sign fix-up in the final cycle, results held in HI/LO.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [4:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int unsigned CW = $clog2(WIDTH);

   state_t             state_q;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   opb_q;
   logic               is_div_q;
   logic               neg_q;
   logic               a_neg_q;
   logic               div0_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   mul_addend;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_diff;
   logic [2*WIDTH-1:0] acc_d;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   hi_d;
   logic [WIDTH-1:0]   lo_d;

   // acc_q holds {partial product, multiplier} for MULT and {remainder, quotient} for DIV.
   always_comb begin
      a_neg      = ~op_i[0] & a_i[WIDTH-1];
      b_neg      = ~op_i[0] & b_i[WIDTH-1];
      a_mag      = a_neg ? -a_i : a_i;
      b_mag      = b_neg ? -b_i : b_i;

      mul_addend = acc_q[0] ? opb_q : {WIDTH{1'b0}};
      mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
      rem_shift  = acc_q[2*WIDTH-1:WIDTH-1];
      div_ge     = rem_shift >= {1'b0, opb_q};
      div_diff   = rem_shift[WIDTH-1:0] - opb_q;

      acc_d      = {mul_sum, acc_q[WIDTH-1:1]};
      if (is_div_q) begin
         acc_d = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1} : {acc_q[2*WIDTH-2:0], 1'b0};
      end

      prod_fix   = neg_q ? -acc_q : acc_q;
      quot       = acc_q[WIDTH-1:0];
      rem        = acc_q[2*WIDTH-1:WIDTH];
      hi_d       = prod_fix[2*WIDTH-1:WIDTH];
      lo_d       = prod_fix[WIDTH-1:0];
      if (is_div_q) begin
         hi_d = a_neg_q ? -rem : rem;
         lo_d = div0_q ? {WIDTH{1'b1}} : (neg_q ? -quot : quot);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opb_q    <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         a_neg_q  <= 1'b0;
         div0_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_i && is_mdu_op(op_i)) begin
                  acc_q    <= {{WIDTH{1'b0}}, a_mag};
                  opb_q    <= b_mag;
                  is_div_q <= op_i[1];
                  neg_q    <= a_neg ^ b_neg;
                  a_neg_q  <= a_neg;
                  div0_q   <= (b_i == '0);
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= ST_RUN;
               end
            end
            ST_RUN: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_q <= ST_FIN;
               end
            end
            ST_FIN: begin
               hi_q    <= hi_d;
               lo_q    <= lo_d;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: rtl/alu_mdu.sv
// MIPS ALU: combinational single-cycle ops with zero/overflow flags, plus an
// iterative multiply/divide unit driving HI/LO through a start/busy/done handshake.
module alu_mdu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   shamt,
   input  logic [4:0]       alu_ctrl,
   input  logic             start,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;

   assign sum  = a + b;
   assign diff = a - b;

   // Single-cycle op mux; MDU and undefined codes produce 0.
   always_comb begin
      result   = '0;
      overflow = 1'b0;
      case (alu_ctrl)
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_ADD: begin
            result   = sum;
            overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_XOR:  result = a ^ b;
         OP_SUB: begin
            result   = diff;
            overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT:  result = WIDTH'($signed(a) < $signed(b));
         OP_SLTU: result = WIDTH'(a < b);
         OP_SLL:  result = b << shamt;
         OP_SRL:  result = b >> shamt;
         OP_SRA:  result = WIDTH'($signed(b) >>> shamt);
         OP_NOR:  result = ~(a | b);
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

   alu_muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk     (clk),
      .rst     (rst),
      .start_i (start),
      .op_i    (alu_ctrl),
      .a_i     (a),
      .b_i     (b),
      .busy_o  (busy),
      .done_o  (done),
      .hi_o    (hi),
      .lo_o    (lo)
   );

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: single-cycle ops, MDU latency/results, handshake and reset abort.
module tb_alu_mdu;
   import alu_pkg::*;

   logic        clk;
   logic        rst;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  shamt;
   logic [4:0]  alu_ctrl;
   logic        start;
   logic [31:0] result;
   logic        zero;
   logic        overflow;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_errors = 0;

   alu_mdu #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .shamt    (shamt),
      .alu_ctrl (alu_ctrl),
      .start    (start),
      .result   (result),
      .zero     (zero),
      .overflow (overflow),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic alu_op(input string tag, input logic [4:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input logic [4:0] sh,
                         input logic [31:0] eres, input logic ez, input logic eov);
      alu_ctrl = op; a = av; b = bv; shamt = sh;
      #1;
      check({tag, "_res"}, 64'(result), 64'(eres));
      check({tag, "_zero"}, 64'(zero), 64'(ez));
      check({tag, "_ovf"}, 64'(overflow), 64'(eov));
   endtask

   // Start in the current cycle (cycle 0); returns in the done cycle so calls chain back-to-back.
   task automatic run_mdu(input string tag, input logic [4:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] ehi,
                          input logic [31:0] elo, input bit poke);
      int nbusy;
      int cyc;
      alu_ctrl = op; a = av; b = bv; start = 1'b1;
      tick();
      start = 1'b0; a = ~av; b = ~bv; alu_ctrl = OP_ADD;
      nbusy = 0;
      cyc   = 1;
      while (!done && cyc < 40) begin
         if (busy) nbusy++;
         start    = poke && (cyc == 5);
         alu_ctrl = start ? OP_DIVU : OP_ADD;
         if (cyc == 10) begin
            a = 32'd3; b = 32'd4;
            #1;
            check({tag, "_add_busy"}, 64'(result), 64'd7);
         end
         tick();
         cyc++;
      end
      start = 1'b0;
      check({tag, "_done_cyc"}, 64'(cyc), 64'd34);
      check({tag, "_busy_cnt"}, 64'(nbusy), 64'd33);
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_busy_end"}, 64'(busy), 64'd0);
      check({tag, "_hi"}, 64'(hi), 64'(ehi));
      check({tag, "_lo"}, 64'(lo), 64'(elo));
   endtask

   initial begin
      int ndone;
      int nbusy;
      rst = 1'b1; a = '0; b = '0; shamt = '0; alu_ctrl = OP_AND; start = 1'b0;
      tick();
      tick();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      rst = 1'b0;

      alu_op("add_ovf", OP_ADD,  32'h7FFF_FFFF, 32'h1,         5'd0, 32'h8000_0000, 1'b0, 1'b1);
      alu_op("add",     OP_ADD,  32'd20,        32'hFFFF_FFFB, 5'd0, 32'd15,        1'b0, 1'b0);
      alu_op("sub_z",   OP_SUB,  32'd5,         32'd5,         5'd0, 32'd0,         1'b1, 1'b0);
      alu_op("sub_ovf", OP_SUB,  32'h8000_0000, 32'h1,         5'd0, 32'h7FFF_FFFF, 1'b0, 1'b1);
      alu_op("slt",     OP_SLT,  32'hFFFF_FFFF, 32'h1,         5'd0, 32'd1,         1'b0, 1'b0);
      alu_op("sltu",    OP_SLTU, 32'hFFFF_FFFF, 32'h1,         5'd0, 32'd0,         1'b1, 1'b0);
      alu_op("sra",     OP_SRA,  32'h0,         32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 1'b0);
      alu_op("srl",     OP_SRL,  32'h0,         32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0);
      alu_op("sll",     OP_SLL,  32'h0,         32'h0000_00F1, 5'd8, 32'h0000_F100, 1'b0, 1'b0);
      alu_op("and",     OP_AND,  32'hF0F0_1234, 32'hFF00_FF00, 5'd0, 32'hF000_1200, 1'b0, 1'b0);
      alu_op("or",      OP_OR,   32'hF0F0_0000, 32'h0000_000F, 5'd0, 32'hF0F0_000F, 1'b0, 1'b0);
      alu_op("xor",     OP_XOR,  32'hFFFF_0000, 32'hF0F0_F0F0, 5'd0, 32'h0F0F_F0F0, 1'b0, 1'b0);
      alu_op("nor",     OP_NOR,  32'hFFFF_0000, 32'h0000_00FF, 5'd0, 32'h0000_FF00, 1'b0, 1'b0);
      alu_op("undef",   5'b00100, 32'hFFFF_FFFF, 32'h1,        5'd0, 32'd0,         1'b1, 1'b0);
      alu_op("mdu_res", OP_MULT, 32'h7FFF_FFFF, 32'h1,         5'd0, 32'd0,         1'b1, 1'b0);

      // Start with a non-MDU 1xxxx code must not launch anything.
      alu_ctrl = 5'b10100; a = 32'd9; b = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("bad_start_busy", 64'(busy), 64'd0);

      run_mdu("mult",   OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      run_mdu("multu",  OP_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h1,         32'hFFFF_FFFE, 1'b0);
      run_mdu("div",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_mdu("divu",   OP_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         1'b0);
      run_mdu("divmin", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
      run_mdu("divu0",  OP_DIVU,  32'h1234,      32'd0,         32'h1234,      32'hFFFF_FFFF, 1'b0);
      run_mdu("div0",   OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
      run_mdu("divneg", OP_DIV,   32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2, 1'b0);
      run_mdu("multmn", OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0);
      run_mdu("poke",   OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h1,         32'h0,         1'b1);

      // The ignored second start must not produce another op; HI/LO hold meanwhile.
      ndone = 0;
      nbusy = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done) ndone++;
         if (busy) nbusy++;
      end
      check("poke_extra_done", 64'(ndone), 64'd0);
      check("poke_extra_busy", 64'(nbusy), 64'd0);
      check("hold_hi", 64'(hi), 64'h1);
      check("hold_lo", 64'(lo), 64'h0);

      // Reset during cycle 10 of a MULT aborts it.
      alu_ctrl = OP_MULT; a = 32'd5; b = 32'd6; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 10; c++) tick();
      check("abort_busy_pre", 64'(busy), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_hi", 64'(hi), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) ndone++;
         tick();
      end
      check("abort_no_done", 64'(ndone), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
